camera_capture: RTL and testbench
=================================

Name: camera_capture

Overview:
- Stage directly downstream of the camera byte-assembly interface.
- Consumes its divided pixel clock level and assembled 16-bit RGB565 word, plus camera VSYNC/HREF.
- Produces frame-buffer write transactions: enable, linear address, data.
- Frames each capture on VSYNC, counts pixels and lines, and flags malformed frames; supports single-shot and continuous capture.

Parameters:
H_ACT, 640, active pixels per line
V_ACT, 480, active lines per frame
ADDR_W, 19, frame-buffer address width (must satisfy 2^ADDR_W >= H_ACT*V_ACT)

Ports:
clk  input  1  system clock, 25 MHz; all inputs synchronous to it
rst  input  1  synchronous reset, active-high
start_i  input  1  capture request, level sampled in IDLE
continuous_i  input  1  1 = re-arm after each frame; sampled at frame end
vsync_i  input  1  camera VSYNC, high = vertical sync
href_i  input  1  camera HREF, high = active line
pix_clk_i  input  1  divided pixel clock level from byte-assembly stage
pix_data_i  input  16  assembled pixel word from byte-assembly stage
wr_en_o  output  1  frame-buffer write strobe
wr_addr_o  output  ADDR_W  frame-buffer write address
wr_data_o  output  16  frame-buffer write data
busy_o  output  1  high in ARM or ACTIVE
frame_done_o  output  1  one-cycle pulse at end of captured frame
err_o  output  2  sticky; bit0 line-length error, bit1 line-count error

Behaviour:
- Registers: pix_clk_q, href_q, href_qq, vsync_q (one-cycle delayed copies).
- Pixel strobe: pix_clk_q==1 && pix_clk_i==0 && href_q==1. pix_data_i is complete in that cycle.
  - A falling pix_clk caused by HREF dropping does not qualify, because href_q==0 then.
- Line end: href_qq==1 && href_q==0.
- Frame start: vsync_q==1 && vsync_i==0.
- Frame end: vsync_q==0 && vsync_i==1.
- FSM states: IDLE, ARM, ACTIVE.
  - IDLE -> ARM on start_i==1; err_o cleared on this transition.
  - ARM -> ACTIVE on frame start. Counters x=0, y=0, addr=0.
    - A start received mid-frame waits for the next full VSYNC pulse.
  - ACTIVE -> frame end: frame_done_o pulses one cycle. Next state is ARM if continuous_i==1, else IDLE.
  - start_i ignored outside IDLE.
- Pixel strobe in ACTIVE:
  - If x<H_ACT and y<V_ACT: write pix_data_i at addr, then addr++.
  - x++ in all cases (x saturates at H_ACT+1).
- Write port:
  - wr_en_o, wr_addr_o, wr_data_o registered; latency 1 cycle after strobe.
  - wr_en_o is high for exactly one cycle per accepted pixel.
- Address is an incremental counter with no multiplier: row-major, addr = y*H_ACT + x.
- Line end in ACTIVE:
  - If x != H_ACT, set err_o[0].
  - Then x=0; y++ (y saturates at V_ACT+1).
  - A short line leaves the addr counter unadjusted. Subsequent pixels of the frame pack contiguously; err_o[0] marks the frame invalid.
- Lines beyond V_ACT produce no writes.
- At frame end, if y != V_ACT, set err_o[1].
- Simultaneous events:
  - Pixel strobe and line end in the same cycle: pixel processed first, then line end.
  - Frame end coinciding with line end: line end processed, then frame end.
- Reset: state IDLE; all outputs 0, including wr_addr_o, wr_data_o and err_o; counters 0. Reset mid-frame abandons the frame with no frame_done_o pulse.

Optional Feature:
- Macro CAPTURE_DECIM_EN defined: 2x2 decimation.
  - A pixel is written only when x and y are both even.
  - addr advances only on written pixels, giving (H_ACT/2)*(V_ACT/2) writes per frame.
  - H_ACT and V_ACT must be even.
  - Error checks still use the full-resolution x/y counts.
- Macro undefined: every accepted pixel is written.

Test Plan:
- H_ACT=4, V_ACT=3; start_i pulse, VSYNC pulse, 3 lines of 4 pixels (data 0x0000..0x000B), VSYNC rise -> 12 writes, addr 0..11 with data equal to addr, one frame_done_o pulse, err_o=0, back to IDLE, busy_o=0.
- start_i asserted while VSYNC low mid-frame -> no writes until the following VSYNC high->low; then a full, correct frame is captured.
- Line 1 carries 3 pixels (HREF drops early, pix_clk forced low after a single byte) -> err_o[0]=1; the partial byte is not written; 11 writes total; err_o held until the next start.
- Frame of 2 lines only -> err_o[1]=1 at frame end; frame_done_o still pulses.
- continuous_i=1 over two frames -> second frame's writes restart at addr 0; two frame_done_o pulses; busy_o stays high between frames. Asserting rst mid-frame -> all outputs 0 next cycle and no frame_done_o pulse.
- CAPTURE_DECIM_EN, H_ACT=4, V_ACT=4, data=x+4y -> 4 writes: addr0=0x0, addr1=0x2, addr2=0x8, addr3=0xA.

Source files
------------

// File: rtl/camera_capture.sv
// camera_capture: turns assembled RGB565 pixels plus VSYNC/HREF into linear
// frame-buffer writes, with per-frame line-length and line-count checking.
// Optional build macro CAPTURE_DECIM_EN enables 2x2 decimation: only pixels
// at even x and even y are written.
module camera_capture #(
  parameter int H_ACT  = 640,
  parameter int V_ACT  = 480,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              continuous_i,
  input  logic              vsync_i,
  input  logic              href_i,
  input  logic              pix_clk_i,
  input  logic [15:0]       pix_data_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [15:0]       wr_data_o,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic [1:0]        err_o
);

  // Counters reach one past the active size so over-long lines/frames stay
  // distinguishable from exact ones.
  localparam int XW = $clog2(H_ACT + 2);
  localparam int YW = $clog2(V_ACT + 2);
  localparam logic [XW-1:0] X_ACT = XW'(H_ACT);
  localparam logic [YW-1:0] Y_ACT = YW'(V_ACT);
  localparam logic [XW-1:0] X_MAX = XW'(H_ACT + 1);
  localparam logic [YW-1:0] Y_MAX = YW'(V_ACT + 1);

  typedef enum logic [1:0] {IDLE, ARM, ACTIVE} state_t;

  state_t              state_q, state_d;
  logic                pix_clk_q, href_q, href_qq, vsync_q;
  logic [XW-1:0]       x_q, x_d, x_pix;
  logic [YW-1:0]       y_q, y_d, y_line;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          err_d;
  logic                done_d;
  logic                take;
  logic                keep_pix;
  logic                pix_stb, line_end, frame_start, frame_end;

  function automatic logic [XW-1:0] sat_inc_x(input logic [XW-1:0] v);
    return (v == X_MAX) ? v : v + XW'(1);
  endfunction

  function automatic logic [YW-1:0] sat_inc_y(input logic [YW-1:0] v);
    return (v == Y_MAX) ? v : v + YW'(1);
  endfunction

  // A pixel completes when the divided pixel clock falls inside an active line;
  // the one-cycle-delayed HREF rejects the fall caused by HREF itself dropping.
  assign pix_stb     = pix_clk_q & ~pix_clk_i & href_q;
  assign line_end    = href_qq & ~href_q;
  assign frame_start = vsync_q & ~vsync_i;
  assign frame_end   = ~vsync_q & vsync_i;
  assign busy_o      = (state_q != IDLE);

`ifdef CAPTURE_DECIM_EN
  assign keep_pix = ~x_q[0] & ~y_q[0];
`else
  assign keep_pix = 1'b1;
`endif

  // Next state and counter update; within one cycle the pixel is applied
  // first, then line end, then frame end.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    x_pix   = x_q;
    y_line  = y_q;
    addr_d  = addr_q;
    err_d   = err_o;
    done_d  = 1'b0;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = ARM;
          err_d   = 2'b00;
        end
      end
      ARM: begin
        if (frame_start) begin
          state_d = ACTIVE;
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
        end
      end
      ACTIVE: begin
        if (pix_stb) begin
          if ((x_q < X_ACT) && (y_q < Y_ACT) && keep_pix) begin
            take   = 1'b1;
            addr_d = addr_q + ADDR_W'(1);
          end
          x_pix = sat_inc_x(x_q);
        end
        x_d = x_pix;
        if (line_end) begin
          if (x_pix != X_ACT) err_d[0] = 1'b1;
          x_d    = '0;
          y_line = sat_inc_y(y_q);
        end
        y_d = y_line;
        if (frame_end) begin
          if (y_line != Y_ACT) err_d[1] = 1'b1;
          done_d  = 1'b1;
          state_d = continuous_i ? ARM : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Input edge-detect history, state, counters and the registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pix_clk_q    <= 1'b0;
      href_q       <= 1'b0;
      href_qq      <= 1'b0;
      vsync_q      <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      addr_q       <= '0;
      wr_en_o      <= 1'b0;
      wr_addr_o    <= '0;
      wr_data_o    <= '0;
      frame_done_o <= 1'b0;
      err_o        <= 2'b00;
    end else begin
      state_q      <= state_d;
      pix_clk_q    <= pix_clk_i;
      href_q       <= href_i;
      href_qq      <= href_q;
      vsync_q      <= vsync_i;
      x_q          <= x_d;
      y_q          <= y_d;
      addr_q       <= addr_d;
      wr_en_o      <= take;
      if (take) begin
        wr_addr_o  <= addr_q;
        wr_data_o  <= pix_data_i;
      end
      frame_done_o <= done_d;
      err_o        <= err_d;
    end
  end

endmodule

// File: tb/tb_camera_capture.sv
// Directed bench for camera_capture with a tiny frame geometry.
module tb_camera_capture;

  localparam int H  = 4;
`ifdef CAPTURE_DECIM_EN
  localparam int V  = 4;
`else
  localparam int V  = 3;
`endif
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i, continuous_i, vsync_i, href_i, pix_clk_i;
  logic [15:0]   pix_data_i;
  logic          wr_en_o;
  logic [AW-1:0] wr_addr_o;
  logic [15:0]   wr_data_o;
  logic          busy_o, frame_done_o;
  logic [1:0]    err_o;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int pix_idx = 0;
  int d0;
  int addr_log[$];
  int data_log[$];

  camera_capture #(.H_ACT(H), .V_ACT(V), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .continuous_i(continuous_i),
    .vsync_i(vsync_i), .href_i(href_i), .pix_clk_i(pix_clk_i),
    .pix_data_i(pix_data_i), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o),
    .wr_data_o(wr_data_o), .busy_o(busy_o), .frame_done_o(frame_done_o),
    .err_o(err_o)
  );

  always #20 clk = ~clk;

  // Log every write strobe and frame-done pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_en_o === 1'b1) begin
      addr_log.push_back(int'(wr_addr_o));
      data_log.push_back(int'(wr_data_o));
    end
    if (frame_done_o === 1'b1) done_cnt++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_pixel(input int d);
    pix_data_i = 16'(d);
    pix_clk_i  = 1'b1;
    cyc(2);
    pix_clk_i  = 1'b0;
    cyc(2);
  endtask

  // Line of npix pixels with data base..base+npix-1; a short tail leaves a
  // half pixel whose pix_clk fall follows the HREF drop.
  task automatic send_line(input int npix, input int base, input bit short_tail);
    href_i = 1'b1;
    cyc(2);
    for (int i = 0; i < npix; i++) send_pixel(base + i);
    if (short_tail) begin
      pix_data_i = 16'hFFFF;
      pix_clk_i  = 1'b1;
      cyc(2);
      href_i     = 1'b0;
      cyc(1);
      pix_clk_i  = 1'b0;
      cyc(3);
    end else begin
      href_i = 1'b0;
      cyc(3);
    end
  endtask

  // VSYNC pulse, nlines lines (line short_ln carries 3 pixels), then the
  // VSYNC rise that ends the frame; VSYNC is left high.
  task automatic frame(input int nlines, input int short_ln);
    int n;
    vsync_i = 1'b1;
    cyc(3);
    vsync_i = 1'b0;
    cyc(3);
    for (int l = 0; l < nlines; l++) begin
      n = (l == short_ln) ? 3 : H;
      send_line(n, pix_idx, l == short_ln);
      pix_idx += n;
    end
    vsync_i = 1'b1;
    cyc(3);
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    cyc(1);
    start_i = 1'b0;
  endtask

  task automatic clear_log();
    addr_log.delete();
    data_log.delete();
    pix_idx = 0;
  endtask

  task automatic check_writes(input string tag, input int n);
    check_val($sformatf("%s count", tag), addr_log.size(), n);
    for (int i = 0; i < addr_log.size() && i < n; i++) begin
      check_val($sformatf("%s addr%0d", tag, i), addr_log[i], i);
      check_val($sformatf("%s data%0d", tag, i), data_log[i], i);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, " wr_en"}, wr_en_o, 0);
    check_val({tag, " wr_addr"}, wr_addr_o, 0);
    check_val({tag, " wr_data"}, wr_data_o, 0);
    check_val({tag, " busy"}, busy_o, 0);
    check_val({tag, " done"}, frame_done_o, 0);
    check_val({tag, " err"}, err_o, 0);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; continuous_i = 1'b0; vsync_i = 1'b0;
    href_i = 1'b0; pix_clk_i = 1'b0; pix_data_i = 16'h0000;
    cyc(3);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

`ifdef CAPTURE_DECIM_EN
    pulse_start();
    clear_log();
    d0 = done_cnt;
    vsync_i = 1'b1; cyc(3); vsync_i = 1'b0; cyc(3);
    for (int l = 0; l < V; l++) send_line(H, H * l, 1'b0);
    vsync_i = 1'b1; cyc(3);
    @(negedge clk);
    check_val("decim count", addr_log.size(), 4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
      check_val($sformatf("decim addr%0d", i), addr_log[i], i);
      check_val($sformatf("decim data%0d", i), data_log[i], (i % 2) * 2 + (i / 2) * 8);
    end
    check_val("decim err", err_o, 0);
    check_val("decim done", done_cnt - d0, 1);
`else
    // Single-shot full frame
    pulse_start();
    @(negedge clk);
    check_val("t1 busy armed", busy_o, 1);
    clear_log();
    d0 = done_cnt;
    frame(3, -1);
    @(negedge clk);
    check_writes("t1", 12);
    check_val("t1 done", done_cnt - d0, 1);
    check_val("t1 err", err_o, 0);
    check_val("t1 busy", busy_o, 0);

    // Start arrives mid-frame: wait for the next VSYNC fall
    vsync_i = 1'b0;
    cyc(2);
    pulse_start();
    clear_log();
    send_line(H, 100, 1'b0);
    send_line(H, 100, 1'b0);
    check_val("t2 armed writes", addr_log.size(), 0);
    check_val("t2 busy", busy_o, 1);
    clear_log();
    d0 = done_cnt;
    frame(3, -1);
    @(negedge clk);
    check_writes("t2", 12);
    check_val("t2 done", done_cnt - d0, 1);
    check_val("t2 err", err_o, 0);

    // Short line 1
    pulse_start();
    clear_log();
    frame(3, 1);
    @(negedge clk);
    check_writes("t3", 11);
    check_val("t3 err", err_o, 2'b01);
    check_val("t3 busy", busy_o, 0);
    cyc(10);
    check_val("t3 err held", err_o, 2'b01);

    // Two-line frame
    pulse_start();
    @(negedge clk);
    check_val("t4 err cleared", err_o, 0);
    clear_log();
    d0 = done_cnt;
    frame(2, -1);
    @(negedge clk);
    check_writes("t4", 8);
    check_val("t4 err", err_o, 2'b10);
    check_val("t4 done", done_cnt - d0, 1);

    // Four-line frame: extra line is not written
    pulse_start();
    clear_log();
    frame(4, -1);
    @(negedge clk);
    check_writes("t5", 12);
    check_val("t5 err", err_o, 2'b10);

    // Continuous capture over two frames
    continuous_i = 1'b1;
    pulse_start();
    clear_log();
    d0 = done_cnt;
    frame(3, -1);
    @(negedge clk);
    check_writes("t6 f1", 12);
    check_val("t6 busy between", busy_o, 1);
    check_val("t6 done f1", done_cnt - d0, 1);
    clear_log();
    frame(3, -1);
    @(negedge clk);
    check_writes("t6 f2", 12);
    check_val("t6 done f2", done_cnt - d0, 2);
    check_val("t6 err", err_o, 0);
    check_val("t6 busy", busy_o, 1);

    // Reset in the middle of the third frame
    vsync_i = 1'b0;
    cyc(3);
    href_i = 1'b1;
    cyc(2);
    send_pixel(16'h00A5);
    pix_data_i = 16'h005A;
    pix_clk_i  = 1'b1;
    cyc(2);
    pix_clk_i  = 1'b0;
    rst        = 1'b1;
    cyc(1);
    rst          = 1'b0;
    continuous_i = 1'b0;
    @(negedge clk);
    check_all_zero("t7 rst");
    clear_log();
    d0 = done_cnt;
    cyc(2);
    href_i = 1'b0;
    cyc(3);
    vsync_i = 1'b1;
    cyc(4);
    check_val("t7 no done", done_cnt - d0, 0);
    check_val("t7 no writes", addr_log.size(), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
